// File: rtl/fw_tile_sched_if.sv
// Bus bundle between the tile memory/DMA front end, the Floyd-Warshall tile
// sequencer and PE 0 of the linear array.
interface fw_tile_sched_if #(
  parameter int B        = 16,
  parameter int L        = 4,
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 3
);
  localparam int LOGB        = $clog2(B);
  localparam int LOGL        = $clog2(L);
  localparam int W           = B / L;
  localparam int ADDR_WIDTH  = (W > 1) ? $clog2(W) : 1;
  localparam int INSTR_WIDTH = OP_WIDTH + LOGL + ADDR_WIDTH + LOGB + 1;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [L*WIDTH-1:0]     in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] pe_instr;
  logic [L*WIDTH-1:0]     pe_data;
  logic                   res_valid;

  // Sequencer side
  modport slave (
    input  start, in_data, in_valid, res_valid,
    output busy, done, in_ready, pe_instr, pe_data
  );

  // Front end / array side
  modport master (
    output start, in_data, in_valid, res_valid,
    input  busy, done, in_ready, pe_instr, pe_data
  );
endinterface

// File: rtl/fw_tile_sched.sv
// Floyd-Warshall tile sequencer: turns a B x B tile vector stream into
// READ0 / READ1 / COMPUTE instructions for PE 0 and waits for the array to drain.
module fw_tile_sched #(
  parameter int B        = 16,
  parameter int L        = 4,
  parameter int WIDTH    = 16,
  parameter int OP_WIDTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  fw_tile_sched_if.slave bus
);
  localparam int LOGB        = $clog2(B);
  localparam int LOGL        = $clog2(L);
  localparam int W           = B / L;
  localparam int LOGW        = $clog2(W);
  localparam int ADDR_WIDTH  = (W > 1) ? LOGW : 1;
  localparam int INSTR_WIDTH = OP_WIDTH + LOGL + ADDR_WIDTH + LOGB + 1;
  localparam int CNT_WIDTH   = LOGB + ADDR_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] BEATS     = CNT_WIDTH'(B * W);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(B * W - 1);

  localparam logic [OP_WIDTH-1:0] OP_READ0   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_READ1   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_COMPUTE = OP_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_COMPUTE,
    S_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   beatCnt_q, beatCnt_d;
  logic [CNT_WIDTH-1:0]   resCnt_q, resCnt_d;
  logic [INSTR_WIDTH-1:0] peInstr_q, peInstr_d;
  logic [L*WIDTH-1:0]     peData_q, peData_d;
  logic                   done_q, done_d;

  logic                   inReady;
  logic                   accept;
  logic                   lastBeat;
  logic [LOGB-1:0]        pivot;
  logic [ADDR_WIDTH-1:0]  rowAddr;
  logic [ADDR_WIDTH-1:0]  kAddr;
  logic [LOGL-1:0]        kPart;

  function automatic logic [INSTR_WIDTH-1:0] encode(
    input logic [OP_WIDTH-1:0]   op,
    input logic [LOGL-1:0]       part,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [LOGB-1:0]       peId,
    input logic                  last
  );
    return {last, peId, addr, part, op};
  endfunction

  assign inReady  = (state_q == S_LOAD0) || (state_q == S_LOAD1) || (state_q == S_COMPUTE);
  assign accept   = bus.in_valid & inReady;
  assign lastBeat = (beatCnt_q == LAST_BEAT);

  // Beat j maps to row j/W; in COMPUTE that row index doubles as pivot k
  assign pivot   = LOGB'(beatCnt_q >> LOGW);
  assign rowAddr = ADDR_WIDTH'(beatCnt_q & CNT_WIDTH'(W - 1));
  assign kAddr   = ADDR_WIDTH'(pivot >> LOGL);
  assign kPart   = LOGL'(pivot & LOGB'(L - 1));

  assign bus.in_ready = inReady;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.pe_instr = peInstr_q;
  assign bus.pe_data  = peData_q;

  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    resCnt_d  = resCnt_q;
    peInstr_d = '0;
    peData_d  = '0;
    done_d    = 1'b0;

    // Results only count once pivots are flowing; load-phase strobes are noise
    if (((state_q == S_COMPUTE) || (state_q == S_DRAIN)) && bus.res_valid) begin
      resCnt_d = resCnt_q + CNT_WIDTH'(1);
    end

    if (accept) begin
      peData_d  = bus.in_data;
      beatCnt_d = lastBeat ? '0 : beatCnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_LOAD0;
          beatCnt_d = '0;
          resCnt_d  = '0;
        end
      end
      S_LOAD0: begin
        if (accept) begin
          peInstr_d = encode(OP_READ0, '0, rowAddr, pivot, 1'b0);
          if (lastBeat) state_d = S_LOAD1;
        end
      end
      S_LOAD1: begin
        if (accept) begin
          peInstr_d = encode(OP_READ1, '0, rowAddr, pivot, 1'b0);
          if (lastBeat) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (accept) begin
          peInstr_d = encode(OP_COMPUTE, kPart, kAddr, '0, lastBeat);
          if (lastBeat) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (resCnt_d >= BEATS) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beatCnt_q <= '0;
      resCnt_q  <= '0;
      peInstr_q <= '0;
      peData_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      resCnt_q  <= resCnt_d;
      peInstr_q <= peInstr_d;
      peData_q  <= peData_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_fw_tile_sched.sv
// Directed bench for fw_tile_sched with B=16, L=4: instruction table, stalls,
// drain completion, start-while-busy and mid-tile reset.
module tb_fw_tile_sched;
  localparam int B        = 16;
  localparam int L        = 4;
  localparam int WIDTH    = 16;
  localparam int OP_WIDTH = 3;
  localparam int NBEATS   = 192;

  typedef struct {
    int          beat;
    logic [11:0] instr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   readyErr, bubbleErr, doneErr;
  int   nRes;

  logic [11:0] capInstr[NBEATS];
  logic [63:0] capData[NBEATS];
  vec_t        vecs[12];

  fw_tile_sched_if #(.B(B), .L(L), .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

  fw_tile_sched #(.B(B), .L(L), .WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mkInstr(input int op, input int part, input int addr,
                                          input int pe, input bit last);
    return {last, 4'(pe), 2'(addr), 2'(part), 3'(op)};
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    checkOutput({tag, "_pe_instr"}, 64'(bus.pe_instr), 64'd0);
    checkOutput({tag, "_pe_data"}, bus.pe_data, 64'd0);
  endtask

  task automatic applyStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checkOutput("start_busy", 64'(bus.busy), 64'd1);
    checkOutput("start_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // Streams beats 0..nBeats-1 with data=beat index; stalls every third cycle when asked
  task automatic applyStimulus(input int nBeats, input bit stall, input bit resInLoad,
                               input int resInCompute, input int startAt, output int resSent);
    int b = 0;
    int c = 0;
    bit vld;
    resSent   = 0;
    readyErr  = 0;
    bubbleErr = 0;
    doneErr   = 0;
    while (b < nBeats && c < 1000) begin
      vld           = !(stall && (c % 3 == 2));
      bus.in_valid  = vld;
      bus.in_data   = 64'(b);
      bus.start     = (c == startAt);
      bus.res_valid = 1'b0;
      if (b < 128 && resInLoad) begin
        bus.res_valid = 1'b1;
      end else if (b >= 128 && resSent < resInCompute) begin
        bus.res_valid = 1'b1;
        resSent++;
      end
      if (bus.in_ready !== 1'b1) readyErr++;
      tick();
      if (vld) begin
        capInstr[b] = bus.pe_instr;
        capData[b]  = bus.pe_data;
        b++;
      end else if (bus.pe_instr !== '0 || bus.pe_data !== '0) begin
        bubbleErr++;
      end
      if (bus.done !== 1'b0) doneErr++;
      c++;
    end
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    if (b < nBeats) checkOutput("stream_cycle_budget", 64'(b), 64'(nBeats));
  endtask

  task automatic checkStream(input string tag);
    int dataErr = 0;
    foreach (vecs[i]) begin
      checkOutput($sformatf("%s_instr_beat%0d", tag, vecs[i].beat),
                  64'(capInstr[vecs[i].beat]), 64'(vecs[i].instr));
    end
    for (int b = 0; b < NBEATS; b++) begin
      if (capData[b] !== 64'(b)) dataErr++;
    end
    checkOutput({tag, "_data_errors"}, 64'(dataErr), 64'd0);
    checkOutput({tag, "_ready_errors"}, 64'(readyErr), 64'd0);
    checkOutput({tag, "_bubble_errors"}, 64'(bubbleErr), 64'd0);
    checkOutput({tag, "_early_done"}, 64'(doneErr), 64'd0);
  endtask

  // Sends n result strobes with gaps; done must fire exactly on the last one
  task automatic drainRes(input string tag, input int n);
    int early = 0;
    tick();
    checkOutput({tag, "_drain_in_ready"}, 64'(bus.in_ready), 64'd0);
    checkOutput({tag, "_drain_busy"}, 64'(bus.busy), 64'd1);
    checkOutput({tag, "_drain_pe_instr"}, 64'(bus.pe_instr), 64'd0);
    for (int p = 1; p <= n; p++) begin
      bus.res_valid = 1'b1;
      tick();
      bus.res_valid = 1'b0;
      if (p < n) begin
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) early++;
        tick();
        if (bus.done !== 1'b0) early++;
      end
    end
    checkOutput({tag, "_early_or_missing_busy"}, 64'(early), 64'd0);
    checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
    checkOutput({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    tick();
    checkOutput({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{0,   mkInstr(1, 0, 0, 0, 0)};
    vecs[1]  = '{5,   mkInstr(1, 0, 1, 1, 0)};
    vecs[2]  = '{15,  mkInstr(1, 0, 3, 3, 0)};
    vecs[3]  = '{63,  mkInstr(1, 0, 3, 15, 0)};
    vecs[4]  = '{64,  mkInstr(2, 0, 0, 0, 0)};
    vecs[5]  = '{70,  mkInstr(2, 0, 2, 1, 0)};
    vecs[6]  = '{127, mkInstr(2, 0, 3, 15, 0)};
    vecs[7]  = '{128, mkInstr(3, 0, 0, 0, 0)};
    vecs[8]  = '{150, mkInstr(3, 1, 1, 0, 0)};
    vecs[9]  = '{163, mkInstr(3, 0, 2, 0, 0)};
    vecs[10] = '{189, mkInstr(3, 3, 3, 0, 0)};
    vecs[11] = '{191, mkInstr(3, 3, 3, 0, 1)};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkIdleOutputs($sformatf("reset_idle%0d", i));
    end

    $display("[TB] tile 1: no stalls, start pulsed while busy");
    applyStart();
    applyStimulus(NBEATS, 1'b0, 1'b0, 0, 30, nRes);
    checkStream("nostall");
    drainRes("nostall", 64);

    $display("[TB] tile 2: stalls, strobes during load and compute");
    applyStart();
    applyStimulus(NBEATS, 1'b1, 1'b1, 10, -1, nRes);
    checkStream("stall");
    drainRes("stall", 64 - nRes);

    $display("[TB] tile 3: reset at compute beat 10");
    applyStart();
    applyStimulus(138, 1'b0, 1'b0, 0, -1, nRes);
    checkOutput("pre_reset_beat137", 64'(capInstr[137]), 64'(mkInstr(3, 2, 0, 0, 0)));
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 64'd138;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    checkIdleOutputs("midreset");
    tick();
    checkIdleOutputs("midreset_hold");

    $display("[TB] tile 4: clean tile after reset");
    applyStart();
    applyStimulus(NBEATS, 1'b0, 1'b0, 0, -1, nRes);
    checkStream("after_reset");
    drainRes("after_reset", 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
